// File: rtl/data_ram_if.sv
// Load/store bus between the MEM stage and the wait-stated data RAM.
// The master issues requests; the slave answers with ready, read data and a stall request.
interface data_ram_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        stall_req_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o, ready_o, stall_req_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o, ready_o, stall_req_o
    );
endinterface

// File: rtl/data_ram_wait.sv
// Big-endian, byte-selectable data RAM with a configurable number of wait states.
// Requests are latched on acceptance, so the master may change its inputs while the access is pending.
module data_ram_wait #(
    parameter int ADDR_W      = 17,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    data_ram_if.slave  bus
);

    // state   | meaning
    // ST_IDLE | no access pending; ce_i accepts a new request
    // ST_WAIT | wait states counting down; ce_i low aborts
    // ST_DONE | ready_o high; access performed on the edge leaving this state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_o_q, data_o_d;
    logic                ready_q, ready_d;

    logic [31:0]         mem [2**ADDR_W];

    // Byte-offset and aliased upper address bits play no part in the access.
    logic addr_unused;
    assign addr_unused = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        word_d   = word_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        data_o_d = data_o_q;
        ready_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ce_i) begin
                    we_d    = bus.we_i;
                    word_d  = bus.addr_i[ADDR_W+1:2];
                    sel_d   = bus.sel_i;
                    wdata_d = bus.data_i;
                    cnt_d   = WAIT_LD;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.ce_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!we_q) begin
                    data_o_d = mem[word_q];
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            word_q   <= '0;
            sel_q    <= 4'd0;
            wdata_q  <= 32'd0;
            data_o_q <= 32'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            word_q   <= word_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            data_o_q <= data_o_d;
            ready_q  <= ready_d;
        end
    end

    // Contents survive reset; a reset in DONE drops the pending write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_DONE && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[word_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign bus.data_o      = data_o_q;
    assign bus.ready_o     = ready_q;
    assign bus.stall_req_o = (state_q == ST_IDLE && bus.ce_i) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_data_ram_wait.sv
// Scoreboard bench for data_ram_wait: a WAIT_CYCLES=2 instance under random traffic
// and a WAIT_CYCLES=0 instance for the back-to-back timing case.
module tb_data_ram_wait;
    localparam int AW   = 17;
    localparam int WC   = 2;
    localparam int AW_B = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_ram_if bus_a();
    data_ram_if bus_b();

    data_ram_wait #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    data_ram_wait #(.ADDR_W(AW_B), .WAIT_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        bit          is_read;
        bit          known;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    // Monitor: pops one expectation per ready_o pulse; read data is visible once DONE has ended.
    bit   pend = 1'b0;
    exp_t pend_e;
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (pend_e.known) chk({"rdata ", pend_e.tag}, bus_a.data_o, pend_e.data);
        end
        if (bus_a.ready_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready_o=1 expected no completion");
            end else begin
                pend_e = exp_q.pop_front();
                if (pend_e.is_read) pend = 1'b1;
            end
        end
    end

    task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] data, input int abort_at, input string tag);
        exp_t        e;
        int          w;
        bit          fin;
        logic [31:0] m;
        w = widx(addr);
        if (abort_at == 0) begin
            e.is_read = !we;
            e.tag     = tag;
            e.known   = ref_mem.exists(w);
            e.data    = e.known ? ref_mem[w] : 32'd0;
            if (we) begin
                if (ref_mem.exists(w)) begin
                    m = ref_mem[w];
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) m[b*8 +: 8] = data[b*8 +: 8];
                    ref_mem[w] = m;
                end else if (sel == 4'hF) begin
                    ref_mem[w] = data;
                end
            end
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus_a.ce_i   = 1'b1;
        bus_a.we_i   = we;
        bus_a.addr_i = addr;
        bus_a.sel_i  = sel;
        bus_a.data_i = data;
        @(negedge clk);
        chk({"stall_accept ", tag}, {31'd0, bus_a.stall_req_o}, 32'd1);
        fin = 1'b0;
        for (int n = 1; n <= 40 && !fin; n++) begin
            @(posedge clk); #1;
            if (n == abort_at) bus_a.ce_i = 1'b0;
            bus_a.we_i   = 1'($urandom);
            bus_a.addr_i = $urandom;
            bus_a.sel_i  = 4'($urandom);
            bus_a.data_i = $urandom;
            @(negedge clk);
            if (n == abort_at) begin
                chk({"stall_abort ", tag}, {31'd0, bus_a.stall_req_o}, 32'd1);
                fin = 1'b1;
            end else if (bus_a.ready_o) begin
                chk({"latency ", tag}, 32'(n), 32'(WC + 1));
                chk({"stall_done ", tag}, {31'd0, bus_a.stall_req_o}, 32'd0);
                fin = 1'b1;
            end else begin
                chk({"stall_wait ", tag}, {31'd0, bus_a.stall_req_o}, 32'd1);
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: got no ready_o expected one within 40 cycles", tag);
        end
        if (abort_at != 0) begin
            @(negedge clk);
            chk({"abort_idle_stall ", tag}, {31'd0, bus_a.stall_req_o}, 32'd0);
        end else begin
            @(posedge clk); #1;
            bus_a.ce_i = 1'b0;
        end
    endtask

    task automatic b_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus_b.ce_i   = 1'b1;
        bus_b.we_i   = 1'b1;
        bus_b.sel_i  = 4'hF;
        bus_b.addr_i = addr;
        bus_b.data_i = data;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_write_ready", {31'd0, bus_b.ready_o}, 32'd1);
        @(posedge clk); #1;
        bus_b.ce_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          wd;
        int          ab;
        rst = 1'b1;
        bus_a.ce_i = 1'b0; bus_a.we_i = 1'b0; bus_a.addr_i = '0; bus_a.sel_i = '0; bus_a.data_i = '0;
        bus_b.ce_i = 1'b0; bus_b.we_i = 1'b0; bus_b.addr_i = '0; bus_b.sel_i = '0; bus_b.data_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_a", {31'd0, bus_a.ready_o}, 32'd0);
        chk("rst_stall_a", {31'd0, bus_a.stall_req_o}, 32'd0);
        chk("rst_data_a", bus_a.data_o, 32'd0);
        chk("rst_ready_b", {31'd0, bus_b.ready_o}, 32'd0);
        chk("rst_data_b", bus_b.data_o, 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_no_ready", {31'd0, bus_a.ready_o}, 32'd0);
        chk("idle_data_held", bus_a.data_o, 32'd0);

        access(1'b0, 32'h0,        4'hF, 32'h0,        0, "read_poweron");
        access(1'b1, 32'h100,      4'hF, 32'h11223344, 0, "wr_full");
        access(1'b0, 32'h100,      4'hF, 32'h0,        0, "rd_full");
        access(1'b1, 32'h100,      4'h4, 32'hAABBCCDD, 0, "wr_byte1");
        access(1'b0, 32'h100,      4'hF, 32'h0,        0, "rd_byte1");
        access(1'b1, 32'h104,      4'h0, 32'hFFFFFFFF, 0, "wr_sel0_init");
        access(1'b1, 32'h104,      4'hF, 32'h01020304, 0, "wr_104");
        access(1'b1, 32'h104,      4'h0, 32'hFFFFFFFF, 0, "wr_sel0");
        access(1'b0, 32'h104,      4'hF, 32'h0,        0, "rd_sel0");
        access(1'b1, 32'h200,      4'hF, 32'h0BADCAFE, 0, "wr_200");
        access(1'b1, 32'h200,      4'hF, 32'hDEADBEEF, 1, "wr_200_abort");
        access(1'b0, 32'h200,      4'hF, 32'h0,        0, "rd_200");
        access(1'b1, 32'h0,        4'hF, 32'h5,        0, "wr_alias");
        access(1'b0, 32'(4 << AW), 4'hF, 32'h0,        0, "rd_alias");

        // Reset in the middle of a write's wait states.
        access(1'b1, 32'h300, 4'hF, 32'h0BADF00D, 0, "wr_300");
        access(1'b0, 32'h300, 4'hF, 32'h0,        0, "rd_300_pre");
        @(posedge clk); #1;
        bus_a.ce_i = 1'b1; bus_a.we_i = 1'b1; bus_a.addr_i = 32'h300;
        bus_a.sel_i = 4'hF; bus_a.data_i = 32'hCAFEBABE;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_a.ce_i = 1'b0;
        @(negedge clk);
        chk("rst_wait_ready", {31'd0, bus_a.ready_o}, 32'd0);
        chk("rst_wait_data", bus_a.data_o, 32'd0);
        chk("rst_wait_stall", {31'd0, bus_a.stall_req_o}, 32'd0);
        access(1'b0, 32'h300, 4'hF, 32'h0, 0, "rd_300_post");

        for (int i = 0; i < 8; i++)
            access(1'b1, 32'(i << 2), 4'hF, $urandom, 0, "rnd_init");
        for (int i = 0; i < 80; i++) begin
            wd = $urandom_range(0, 7);
            a  = ($urandom() << (AW + 2)) | 32'(wd << 2) | 32'($urandom_range(0, 3));
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, WC) : 0;
            access(1'($urandom), a, 4'($urandom), $urandom, ab, "rnd");
        end

        // Zero-wait instance: back-to-back reads with ce_i held high.
        b_write(32'h0, 32'hA5A50001);
        b_write(32'h4, 32'h5A5A0002);
        @(posedge clk); #1;
        bus_b.ce_i = 1'b1; bus_b.we_i = 1'b0; bus_b.addr_i = 32'h0; bus_b.sel_i = 4'hF;
        @(negedge clk);
        chk("b2b_c1_ready", {31'd0, bus_b.ready_o}, 32'd0);
        chk("b2b_c1_stall", {31'd0, bus_b.stall_req_o}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_c2_ready", {31'd0, bus_b.ready_o}, 32'd1);
        chk("b2b_c2_stall", {31'd0, bus_b.stall_req_o}, 32'd0);
        @(posedge clk); #1;
        bus_b.addr_i = 32'h4;
        @(negedge clk);
        chk("b2b_c3_ready", {31'd0, bus_b.ready_o}, 32'd0);
        chk("b2b_c3_stall", {31'd0, bus_b.stall_req_o}, 32'd1);
        chk("b2b_c3_data", bus_b.data_o, 32'hA5A50001);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_c4_ready", {31'd0, bus_b.ready_o}, 32'd1);
        chk("b2b_c4_stall", {31'd0, bus_b.stall_req_o}, 32'd0);
        @(posedge clk); #1;
        bus_b.ce_i = 1'b0;
        @(negedge clk);
        chk("b2b_c5_ready", {31'd0, bus_b.ready_o}, 32'd0);
        chk("b2b_c5_stall", {31'd0, bus_b.stall_req_o}, 32'd0);
        chk("b2b_c5_data", bus_b.data_o, 32'h5A5A0002);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2 ms");
        $fatal(1, "timeout");
    end
endmodule
